// File: rtl/adc_emu_pkg.sv
// Shared constants, FSM encoding and frame-word builder for the ADC SPI emulator.
package adc_emu_pkg;

    localparam int DATA_W      = 10;
    localparam int LEAD_ZEROS  = 4;
    localparam int TRAIL_ZEROS = 2;
    localparam int FRAME_LEN   = LEAD_ZEROS + DATA_W + TRAIL_ZEROS;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } emu_state_t;

    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [DATA_W-1:0] sample);
        return {{LEAD_ZEROS{1'b0}}, sample, {TRAIL_ZEROS{1'b0}}};
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall pulses on the synced level.
// settled goes high once the chain holds real pin samples rather than reset values.
module sync_edge_detect #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic settled
);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic [STAGES:0]   vld_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain    <= {STAGES{RST_VAL}};
            prev     <= RST_VAL;
            vld_pipe <= '0;
        end else begin
            chain    <= {chain[STAGES-2:0], din};
            prev     <= chain[STAGES-1];
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
        end
    end

    assign level   = chain[STAGES-1];
    assign rise    = ~prev & level;
    assign fall    = prev & ~level;
    assign settled = vld_pipe[STAGES];

endmodule

// File: rtl/adc_spi_emulator.sv
// SPI slave that stands in for a 10-bit ADC: frames an upstream sample as
// {zeros, sample, zeros} and shifts it out MSB first on synced sclk falling edges.
module adc_spi_emulator
    import adc_emu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_n,
    input  logic              sclk,
    output logic              sdata,
    output logic              sdata_oe,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              underrun
);

    logic cs_lvl, cs_rise, cs_fall, cs_settled;
    logic sclk_fall, sclk_settled, sclk_lvl_unused, sclk_rise_unused;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .din(cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall), .settled(cs_settled)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
        .clk(clk), .reset(reset), .din(sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise_unused), .fall(sclk_fall),
        .settled(sclk_settled)
    );

    emu_state_t           state, state_nxt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [FRAME_LEN-1:0] shreg;
    logic [DATA_W-1:0]    hold, last_sample, frame_sample;
    logic                 hold_full, armed, load, shift, accept;

    // Arm only on a genuine high pin level, never on the synchroniser's reset value.
    always_ff @(posedge clk) begin
        if (reset)
            armed <= 1'b0;
        else if (cs_settled && sclk_settled && cs_lvl)
            armed <= 1'b1;
    end

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        shift       = 1'b0;
        frame_done  = 1'b0;
        frame_abort = 1'b0;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (cs_fall && armed) begin
                        load      = 1'b1;
                        state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // cs_n rise beats a coincident sclk fall
                    if (cs_rise) begin
                        frame_abort = 1'b1;
                        state_nxt   = ST_IDLE;
                    end else if (sclk_fall) begin
                        shift = 1'b1;
                        if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
                            frame_done = 1'b1;
                            state_nxt  = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (cs_rise)
                        state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    assign sdata_oe     = (state == ST_SHIFT);
    assign sdata        = sdata_oe & shreg[FRAME_LEN-1];
    assign sample_ready = !reset && (!hold_full || load);
    assign accept       = sample_valid && sample_ready;
    assign underrun     = load && !hold_full && !sample_valid;
    assign frame_sample = hold_full    ? hold      :
                          sample_valid ? sample_in : last_sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            last_sample <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                shreg       <= build_frame(frame_sample);
                bit_cnt     <= '0;
                last_sample <= frame_sample;
            end else if (shift) begin
                shreg   <= {shreg[FRAME_LEN-2:0], 1'b0};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            // A bypass accept on an empty-hold load goes straight to the frame.
            if (accept && !(load && !hold_full)) begin
                hold      <= sample_in;
                hold_full <= 1'b1;
            end else if (load && hold_full) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_emulator.sv
// Self-checking bench: directed table, multi-cycle corner sequences and randomized
// frames scored against a sample-queue model of the emulator.
module tb_adc_spi_emulator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs_n = 1'b1;
    logic       sclk = 1'b1;
    logic [9:0] sample_in = '0;
    logic       sample_valid = 1'b0;
    logic       sdata, sdata_oe, sample_ready, frame_done, frame_abort, underrun;

    always #5 clk = ~clk;

    adc_spi_emulator dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .sclk(sclk),
        .sdata(sdata), .sdata_oe(sdata_oe),
        .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .frame_done(frame_done), .frame_abort(frame_abort), .underrun(underrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model state: every accepted sample with the cycle it was accepted on.
    typedef struct { logic [9:0] val; int cyc; } acc_t;
    acc_t       acc_q[$];
    logic [9:0] feed_q[$];
    logic [9:0] last_model = '0;
    int cyc = 0, done_cnt = 0, abort_cnt = 0, under_cnt = 0, load_acc = 0;

    always @(posedge clk) begin
        cyc++;
        if (sample_valid && sample_ready) begin
            acc_q.push_back('{sample_in, cyc});
            if (feed_q.size() > 0) feed_q.delete(0);
        end
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
        if (underrun)    under_cnt++;
    end

    always @(negedge clk) begin
        sample_valid = (feed_q.size() != 0);
        sample_in    = (feed_q.size() != 0) ? feed_q[0] : 10'h000;
    end

    // A frame takes the oldest sample accepted on or before its load cycle, else repeats the last.
    task automatic model_consume(input int lc, output logic [9:0] v, output bit und);
        load_acc = 0;
        foreach (acc_q[i]) if (acc_q[i].cyc == lc) load_acc++;
        if (acc_q.size() > 0 && acc_q[0].cyc <= lc) begin
            v = acc_q[0].val;
            acc_q.delete(0);
            und = 1'b0;
        end else begin
            v = last_model;
            und = 1'b1;
        end
        last_model = v;
    endtask

    task automatic run_frame(input int nbits, input string tag, output logic [15:0] w);
        int t0, d0, a0, u0, oe_bad;
        logic [9:0]  ev;
        logic [15:0] ew, mask;
        bit und;
        @(negedge clk);
        d0 = done_cnt; a0 = abort_cnt; u0 = under_cnt;
        cs_n = 1'b0;
        t0 = cyc;
        repeat (7) @(negedge clk);
        w = '0;
        oe_bad = 0;
        for (int i = 0; i < nbits; i++) begin
            w[15-i] = sdata;
            if (sdata_oe !== 1'b1) oe_bad++;
            sclk = 1'b0;
            repeat (7) @(negedge clk);
            sclk = 1'b1;
            repeat (7) @(negedge clk);
        end
        model_consume(t0 + 3, ev, und);
        ew   = 16'(ev) * 16'd4;
        mask = (nbits >= 16) ? 16'hFFFF : ~(16'hFFFF >> nbits);
        check({tag, " word"}, 32'(w & mask), 32'(ew & mask));
        check({tag, " oe during shift"}, oe_bad, 0);
        check({tag, " underrun"}, under_cnt - u0, und ? 1 : 0);
        if (nbits >= 16) begin
            check({tag, " done pulses"}, done_cnt - d0, 1);
            check({tag, " oe after done"}, 32'(sdata_oe), 0);
            cs_n = 1'b1;
            repeat (6) @(negedge clk);
            check({tag, " no abort"}, abort_cnt - a0, 0);
        end else begin
            cs_n = 1'b1;
            repeat (3) @(negedge clk);
            check({tag, " oe after abort"}, 32'(sdata_oe), 0);
            check({tag, " abort pulses"}, abort_cnt - a0, 1);
            check({tag, " no done"}, done_cnt - d0, 0);
            repeat (3) @(negedge clk);
        end
    endtask

    typedef struct { logic [9:0] s; logic [15:0] w; } vec_t;
    vec_t tbl[5];

    initial begin
        logic [15:0] w;
        int d0, oe_bad;
        tbl[0] = '{10'h2A5, 16'h0A94};
        tbl[1] = '{10'h3FF, 16'h0FFC};
        tbl[2] = '{10'h001, 16'h0004};
        tbl[3] = '{10'h200, 16'h0800};
        tbl[4] = '{10'h155, 16'h0554};

        repeat (3) @(negedge clk);
        check("reset outputs", 32'({sdata, sdata_oe, sample_ready, frame_done, frame_abort, underrun}), 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("ready after reset", 32'(sample_ready), 1);

        // Underrun frames resend last_sample, which is zero out of reset.
        run_frame(16, "underrun1", w);
        check("underrun1 raw", 32'(w), 32'h0000);
        run_frame(16, "underrun2", w);
        feed_q.push_back(10'h155);
        repeat (4) @(negedge clk);
        run_frame(16, "fresh155", w);
        check("fresh155 raw", 32'(w), 32'h0554);

        foreach (tbl[i]) begin
            feed_q.push_back(tbl[i].s);
            repeat (4) @(negedge clk);
            run_frame(16, $sformatf("tbl%0d", i), w);
            check($sformatf("tbl%0d raw", i), 32'(w), 32'(tbl[i].w));
        end

        // Abort after 7 bits: the aborted sample is consumed, the next frame moves on.
        feed_q.push_back(10'h3FF);
        feed_q.push_back(10'h001);
        repeat (4) @(negedge clk);
        run_frame(7, "abort", w);
        run_frame(16, "after abort", w);
        check("after abort raw", 32'(w), 32'h0004);

        // Valid held across load cycles: one accept per load, strict order.
        feed_q.push_back(10'h001);
        feed_q.push_back(10'h002);
        feed_q.push_back(10'h003);
        repeat (4) @(negedge clk);
        run_frame(16, "stream1", w);
        check("stream1 raw", 32'(w), 32'h0004);
        check("stream1 load accepts", load_acc, 1);
        run_frame(16, "stream2", w);
        check("stream2 raw", 32'(w), 32'h0008);
        check("stream2 load accepts", load_acc, 1);
        run_frame(16, "stream3", w);
        check("stream3 raw", 32'(w), 32'h000C);

        // Reset in the middle of a frame with cs_n held low.
        feed_q.push_back(10'h0AB);
        repeat (4) @(negedge clk);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (7) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            sclk = 1'b0; repeat (7) @(negedge clk);
            sclk = 1'b1; repeat (7) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        check("oe after reset", 32'(sdata_oe), 0);
        reset = 1'b0;
        acc_q.delete();
        feed_q.delete();
        last_model = '0;
        d0 = done_cnt;
        oe_bad = 0;
        for (int i = 0; i < 20; i++) begin
            sclk = 1'b0; repeat (7) @(negedge clk);
            if (sdata_oe !== 1'b0) oe_bad++;
            sclk = 1'b1; repeat (7) @(negedge clk);
            if (sdata_oe !== 1'b0) oe_bad++;
        end
        check("no frame while unarmed", oe_bad, 0);
        check("no done while unarmed", done_cnt - d0, 0);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        run_frame(16, "post reset", w);

        for (int f = 0; f < 40; f++) begin
            int nb;
            if ($urandom_range(0, 9) < 7) feed_q.push_back(10'($urandom));
            repeat ($urandom_range(2, 30)) @(negedge clk);
            nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : 16;
            run_frame(nb, $sformatf("rand%0d", f), w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1);
    end

endmodule
